// File: rtl/spi_pkg.sv
// Shared constants, FSM encoding and helpers for the SPI master.
// Imported by spi_master_ctrl and spi_master_shifter.
package spi_pkg;

  localparam int CMD_WIDTH_DEF  = 10;
  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    WAIT,
    RECV,
    HOLD,
    GAP
  } state_t;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Command PISO and reply SIPO for the SPI master.
// Ports: load/shift/capture enables, cmd in, miso in, piso_bit/cap_next out.
module spi_master_shifter
  import spi_pkg::*;
#(
  parameter int CMD_WIDTH  = CMD_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  capture,
  input  logic [CMD_WIDTH-1:0]  cmd,
  input  logic                  miso,
  output logic                  piso_bit,
  output logic [DATA_WIDTH-1:0] cap_next
);

  logic [CMD_WIDTH-1:0]  piso;
  // Only DATA_WIDTH-1 bits are stored; the
  // final bit comes straight from miso.
  logic [DATA_WIDTH-2:0] sipo;

  assign piso_bit = piso[CMD_WIDTH-1];
  assign cap_next = {sipo, miso};

  always_ff @(posedge clk) begin
    if (rst) begin
      piso <= '0;
      sipo <= '0;
    end else begin
      if (load)
        piso <= cmd;
      else if (shift)
        piso <= {piso[CMD_WIDTH-2:0], 1'b0};
      if (capture)
        sipo <= cap_next[DATA_WIDTH-2:0];
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: frames commands on SS_n/MOSI, captures read data from MISO.
// Ports: cmd valid/ready/data in, rd_data/rd_valid out, busy, SS_n, MOSI, MISO.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int RD_LATENCY = 3,
  parameter int CMD_WIDTH  = CMD_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CMD_WIDTH-1:0]  cmd_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  SS_n,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int CNT_MAX = max4(CMD_WIDTH, DATA_WIDTH,
                                RD_LATENCY, GAP_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WIDTH - 1);
  localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op;
  logic             load;
  logic             shift;
  logic             capture;
  logic             piso_bit;
  logic [DATA_WIDTH-1:0] cap_next;

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

  assign load    = cmd_ready & cmd_valid;
  // START emits the preamble copy of the MSB and then
  // re-presents it, so the PISO steps once in START.
  assign shift   = (state == START) |
                   ((state == SHIFT) & (cnt != CMD_LAST));
  assign capture = (state == RECV);

  spi_master_shifter #(
    .CMD_WIDTH  (CMD_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .capture  (capture),
    .cmd      (cmd_data),
    .miso     (MISO),
    .piso_bit (piso_bit),
    .cap_next (cap_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= CMD_WR_ADDR;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op    <= cmd_data[CMD_WIDTH-1 -: 2];
            SS_n  <= 1'b0;
            MOSI  <= cmd_data[CMD_WIDTH-1];
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          MOSI  <= piso_bit;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (cnt == CMD_LAST) begin
            MOSI  <= 1'b0;
            cnt   <= '0;
            state <= (op == CMD_RD_DATA) ? WAIT : HOLD;
          end else begin
            MOSI <= piso_bit;
            cnt  <= cnt + ONE;
          end
        end
        WAIT: begin
          if (cnt == LAT_LAST) begin
            cnt   <= '0;
            state <= RECV;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        RECV: begin
          // Last bit lands here so rd_data is fresh in HOLD.
          if (cnt == DAT_LAST) begin
            rd_data  <= cap_next;
            rd_valid <= 1'b1;
            cnt      <= '0;
            state    <= HOLD;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        HOLD: begin
          SS_n  <= 1'b1;
          cnt   <= '0;
          state <= GAP;
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          SS_n  <= 1'b1;
          MOSI  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl.
// Frame-level reference model plus a behavioural slave RAM.
module tb_spi_master_ctrl;

  localparam int CW  = 10;
  localparam int DW  = 8;
  localparam int RL  = 3;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [CW-1:0] cmd_data = '0;
  logic          MISO = 1'b0;
  logic          cmd_ready;
  logic          busy;
  logic          rd_valid;
  logic          SS_n;
  logic          MOSI;
  logic [DW-1:0] rd_data;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_rd = '0;
  logic [7:0]    mem [256];
  logic [7:0]    waddr = '0;
  logic [7:0]    raddr = '0;

  spi_master_ctrl #(
    .GAP_CYCLES (GAP),
    .RD_LATENCY (RL),
    .CMD_WIDTH  (CW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ss"},    32'(SS_n),      32'd1);
    chk({tag, " mosi"},  32'(MOSI),      32'd0);
    chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " busy"},  32'(busy),      32'd0);
    chk({tag, " rdv"},   32'(rd_valid),  32'd0);
    chk({tag, " rdd"},   32'(rd_data),   32'(exp_rd));
  endtask

  // Drives one frame starting in the accept cycle (t=0)
  // and checks every cycle against the frame-level model.
  // abort_t>0 asserts rst in that cycle and returns.
  task automatic frame(
    input logic [CW-1:0] cmd,
    input logic [DW-1:0] reply,
    input bit            hold_valid,
    input int            abort_t
  );
    int   n;
    bit   rd;
    int   len;
    int   rs;
    logic e_mosi;
    string s;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    MISO      = 1'($urandom);
    rd  = (cmd[CW-1 -: 2] == 2'b11);
    len = 2 + CW + (rd ? RL + DW : 0);
    rs  = CW + 2 + RL;
    for (int t = 1; t <= len + GAP; t++) begin
      @(negedge clk);
      if (hold_valid) cmd_data = CW'($urandom);
      else cmd_valid = 1'b0;
      if (t == 1) e_mosi = cmd[CW-1];
      else if (t <= CW + 1) e_mosi = cmd[CW + 1 - t];
      else e_mosi = 1'b0;
      if (rd && t == len) exp_rd = reply;
      s = $sformatf("%03h t%0d", cmd, t);
      chk({s, " ss"}, 32'(SS_n), (t <= len) ? 0 : 1);
      chk({s, " mosi"}, 32'(MOSI), 32'(e_mosi));
      chk({s, " ready"}, 32'(cmd_ready), 32'd0);
      chk({s, " busy"}, 32'(busy), 32'd1);
      chk({s, " rdv"}, 32'(rd_valid),
          (rd && t == len) ? 1 : 0);
      chk({s, " rdd"}, 32'(rd_data), 32'(exp_rd));
      if (t == abort_t) begin
        rst = 1'b1;
        MISO = 1'($urandom);
        return;
      end
      if (rd && t >= rs && t < rs + DW)
        MISO = reply[DW - 1 - (t - rs)];
      else
        MISO = 1'($urandom);
    end
    @(negedge clk);
    chk($sformatf("%03h ready back", cmd),
        32'(cmd_ready), 32'd1);
    chk($sformatf("%03h ss back", cmd),
        32'(SS_n), 32'd1);
  endtask

  // Behavioural slave RAM: addr/data writes, addr then
  // data reads; the read reply is the stored byte.
  task automatic send(
    input logic [CW-1:0] cmd,
    input bit            hold_valid
  );
    logic [1:0] op;
    logic [7:0] pl;
    logic [7:0] reply;
    op = cmd[9:8];
    pl = cmd[7:0];
    reply = (op == 2'b11) ? mem[raddr] : 8'($urandom);
    frame(cmd, reply, hold_valid, 0);
    case (op)
      2'b00: waddr = pl;
      2'b01: mem[waddr] = pl;
      2'b10: raddr = pl;
      default: ;
    endcase
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_idle($sformatf("idle%0d", i));
    end

    send(10'b00_0000_0001, 1'b0);

    send({2'b00, 8'h01}, 1'b0);
    send({2'b01, 8'h0A}, 1'b0);
    send({2'b10, 8'h01}, 1'b0);
    send({2'b11, 8'h00}, 1'b0);
    chk("loop rdd", 32'(rd_data), 32'h0A);

    frame({2'b11, 8'h00}, 8'hA5, 1'b0, 0);
    chk("a5 rdd", 32'(rd_data), 32'hA5);

    for (int i = 0; i < 3; i++)
      send({2'b00, 8'($urandom)}, 1'b1);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle($sformatf("post b2b%0d", i));
    end

    for (int i = 0; i < 12; i++)
      send({2'($urandom), 8'($urandom_range(0, 3))},
           1'($urandom));
    cmd_valid = 1'b0;

    frame({2'b11, 8'h00}, 8'h5C, 1'b0, 16);
    exp_rd = '0;
    @(negedge clk);
    chk("abort ss", 32'(SS_n), 32'd1);
    chk("abort rdv", 32'(rd_valid), 32'd0);
    chk("abort rdd", 32'(rd_data), 32'd0);
    chk("abort ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_idle($sformatf("post abort%0d", i));
    end
    send({2'b01, 8'h33}, 1'b0);
    frame({2'b11, 8'h00}, 8'h96, 1'b0, 0);
    chk("final rdd", 32'(rd_data), 32'h96);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Single-channel SPI master that frames 10-bit commands onto MOSI/SS_n for the SPI slave RAM interface and captures its 8-bit read-data reply from MISO. It sits directly upstream of the slave. A host/bus bridge hands it commands over a valid/ready handshake and receives read data over a one-cycle valid strobe. The block runs on the system clock; there is no separate SCK, and the slave samples on the same clk.

Parameters:
GAP_CYCLES, 2, SS_n-high idle cycles enforced between frames (>=1)
RD_LATENCY, 3, idle cycles between last MOSI bit and first MISO bit on a read-data frame (>=1)
CMD_WIDTH, 10, command frame width; bits [9:8] are the opcode, bits [7:0] are the payload
DATA_WIDTH, 8, read-data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command available
cmd_ready  out  1  block idle; the command is accepted on cmd_valid&&cmd_ready
cmd_data  in  CMD_WIDTH  command: 00 write addr, 01 write data, 10 read addr, 11 read data
rd_data  out  DATA_WIDTH  last captured read data, held until the next read-data frame completes
rd_valid  out  1  one-cycle strobe; rd_data is new
busy  out  1  frame or gap in progress (= !cmd_ready)
SS_n  out  1  slave select, active low, registered
MOSI  out  1  serial out, MSB first, registered
MISO  in  1  serial in from slave

Behaviour:
- Reset (sync, rst=1 at an edge): state IDLE. SS_n=1, MOSI=0, rd_valid=0, rd_data=0, busy=0, cmd_ready=1. Reset mid-frame aborts: SS_n is high from the next cycle, and no rd_valid is issued.
- cmd_ready = (state==IDLE). cmd_valid outside IDLE is ignored and not queued.
- FSM states: IDLE, START, SHIFT, WAIT, RECV, HOLD, GAP.
- Accept at cycle 0. Latch cmd_data into the shift register and go to START.
- START (1 cycle): SS_n=0, MOSI=cmd[9]. This is the preamble bit the slave uses to pick its write or read path.
- SHIFT (CMD_WIDTH cycles): MOSI=cmd[9] down to cmd[0], one bit per cycle, SS_n=0.
- After SHIFT:
  - Opcode 11: go to WAIT.
  - Any other opcode: go to HOLD.
- WAIT (RD_LATENCY cycles): SS_n=0, MOSI=0.
- RECV (DATA_WIDTH cycles): SS_n=0, MOSI=0. MISO is shifted into the capture register MSB first at the rising edge ending each RECV cycle.
- HOLD (1 cycle): SS_n=0, MOSI=0. For opcode 11, rd_data is updated and rd_valid=1 in this cycle only.
- GAP (GAP_CYCLES cycles): SS_n=1, MOSI=0, then IDLE.
- Timing with default parameters:
  - Write frame: SS_n low cycles 1–12, high from 13; cmd_ready=1 at cycle 15.
  - Read-data frame: SS_n low cycles 1–23; RECV cycles 15–22; rd_valid at cycle 23; SS_n high at 24; cmd_ready at 26.
- cmd_valid asserted in the same cycle IDLE is re-entered is accepted in that cycle (back-to-back frames are separated by exactly GAP_CYCLES).
- Counters size to clog2 of max(CMD_WIDTH, DATA_WIDTH, RD_LATENCY, GAP_CYCLES)+1 and never wrap inside a state.
- MISO is not sampled outside RECV. rd_data is unchanged by opcodes 00/01/10.

Decomposition:
- Package spi_pkg holds:
  - opcode constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
  - FSM state encoding
  - default CMD_WIDTH/DATA_WIDTH
- One sub-module, spi_master_shifter, is natural. It combines the CMD_WIDTH PISO and DATA_WIDTH SIPO, with load/shift/capture enables driven by the FSM.

Test Plan:
- Reset then idle → SS_n=1, MOSI=0, cmd_ready=1, rd_valid=0 for 20 cycles.
- Write addr 10'b00_0000_0001 → SS_n low cycles 1–12. MOSI sequence 0,0,0,0,0,0,0,0,0,0,1 on cycles 1–11. cmd_ready returns at cycle 15.
- Full loop with slave model: write addr 0x01, write data 0x0A, read addr 0x01, read data 10'b11_0000_0000 → single rd_valid with rd_data=0x0A at HOLD, SS_n high the next cycle.
- Read-data with MISO model driving 0xA5 MSB first in RECV → rd_data=0xA5. A prior rd_data of 0x0A is held until that rd_valid.
- cmd_valid held high continuously with 3 write commands → exactly 3 frames, each separated by 2 SS_n-high cycles. cmd_ready is low during every frame.
- rst asserted at cycle 16 of a read-data frame → SS_n=1 at 17, no rd_valid, rd_data=0, next command frames normally.
